st7789_receiver: RTL

Display-side counterpart of the ST7789 SPI link: oversamples LCD_SCK/LCD_SDA/LCD_DC from the driver, deserialises bytes, decodes CASET/RASET/RAMWR and converts the pixel stream into write-port transactions for `buffer_ram`. It is used for loopback self-test and as a synthesizable display model in system benches, closing the painter → driver → panel path back into a frame buffer.

---
 rtl/st7789_pkg.sv | 33 +++
 rtl/st7789_spi_deserializer.sv | 82 ++++++++
 rtl/st7789_receiver.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/st7789_pkg.sv
// rtl/st7789_pkg.sv - ST7789 receiver opcodes, FSM states, pixel formats and colour helpers
package st7789_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_RASET,
    ST_RAMWR,
    ST_SKIP,
    ST_COLMOD
  } rx_state_e;

  typedef enum logic {
    FMT_RGB565,
    FMT_RGB666
  } pix_fmt_e;

  // Replicate MSBs into the vacated LSBs so full-scale input maps to 0xFF.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/st7789_spi_deserializer.sv
// rtl/st7789_spi_deserializer.sv - oversampling SPI byte receiver with synchronized panel reset
module st7789_spi_deserializer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_rst,
  input  logic       lcd_sck,
  input  logic       lcd_sda,
  input  logic       lcd_dc,
  output logic       panel_rstn,
  output logic [7:0] byte_tdata,
  output logic       byte_dc,
  output logic       byte_tvalid
);

  logic [2:0] sck_sync_q, sck_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic [1:0] dc_sync_q, dc_sync_d;
  logic [1:0] rst_sync_q, rst_sync_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       dc_q, dc_d;
  logic       valid_q, valid_d;
  logic       sck_rise;

  // SDA/DC second stages line up with the SCK stage that flags the rise.
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];

  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], lcd_sck};
    sda_sync_d = {sda_sync_q[0], lcd_sda};
    dc_sync_d  = {dc_sync_q[0], lcd_dc};
    rst_sync_d = {rst_sync_q[0], lcd_rst};
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_d     = byte_q;
    dc_d       = dc_q;
    valid_d    = 1'b0;
    if (!rst_sync_q[1]) begin
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shift_d   = {shift_q[6:0], sda_sync_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_d  = shift_d;
        dc_d    = dc_sync_q[1];
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sck_sync_q <= '0;
      sda_sync_q <= '0;
      dc_sync_q  <= '0;
      rst_sync_q <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_q     <= '0;
      dc_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      sda_sync_q <= sda_sync_d;
      dc_sync_q  <= dc_sync_d;
      rst_sync_q <= rst_sync_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_q     <= byte_d;
      dc_q       <= dc_d;
      valid_q    <= valid_d;
    end
  end

  assign panel_rstn  = rst_sync_q[1];
  assign byte_tdata  = byte_q;
  assign byte_dc     = dc_q;
  assign byte_tvalid = valid_q;

endmodule

// File: rtl/st7789_receiver.sv
// rtl/st7789_receiver.sv - ST7789 display model: command decode, window walk, RGB expansion to RAM writes
// Define ST7789_RX_COLMOD_EN to decode COLMOD and accept RGB666 pixels.
module st7789_receiver
  import st7789_pkg::*;
#(
  parameter int X_LIMIT = 240,
  parameter int Y_LIMIT = 240,
  localparam int AW = $clog2(X_LIMIT) + $clog2(Y_LIMIT)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          LCD_RST,
  input  logic          LCD_SCK,
  input  logic          LCD_SDA,
  input  logic          LCD_DC,
  output logic [AW-1:0] WRITE_RAM_ADDRESS,
  output logic [7:0]    WRITE_RAM_COLOR_R,
  output logic [7:0]    WRITE_RAM_COLOR_G,
  output logic [7:0]    WRITE_RAM_COLOR_B,
  output logic          WRITE_RAM,
  output logic          FRAME_DONE,
  output logic          CMD_VALID,
  output logic [7:0]    CMD_BYTE
);

  localparam logic [15:0] X_LIM = 16'(X_LIMIT);
  localparam logic [15:0] Y_LIM = 16'(Y_LIMIT);
  localparam logic [15:0] X_MAX = 16'(X_LIMIT - 1);
  localparam logic [15:0] Y_MAX = 16'(Y_LIMIT - 1);

  logic       panel_rstn;
  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       rx_valid;

  st7789_spi_deserializer u_deser (
    .clk         (CLK),
    .resetn      (RESET),
    .lcd_rst     (LCD_RST),
    .lcd_sck     (LCD_SCK),
    .lcd_sda     (LCD_SDA),
    .lcd_dc      (LCD_DC),
    .panel_rstn  (panel_rstn),
    .byte_tdata  (rx_byte),
    .byte_dc     (rx_dc),
    .byte_tvalid (rx_valid)
  );

  rx_state_e     state_q, state_d;
  logic [2:0]    param_idx_q, param_idx_d;
  logic [15:0]   x_start_q, x_start_d, x_end_q, x_end_d;
  logic [15:0]   y_start_q, y_start_d, y_end_q, y_end_d;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    pix0_q, pix0_d;
`ifdef ST7789_RX_COLMOD_EN
  logic [7:0]    pix1_q, pix1_d;
  pix_fmt_e      fmt_q, fmt_d;
`endif
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          write_q, write_d;
  logic          frame_done_q, frame_done_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;

  logic [1:0]    last_phase;
  logic [7:0]    col_r, col_g, col_b;
  logic          in_range;

  // The incoming byte closes the pixel, so colours read it directly.
  always_comb begin
    last_phase = 2'd1;
    col_r      = expand5(pix0_q[7:3]);
    col_g      = expand6({pix0_q[2:0], rx_byte[7:5]});
    col_b      = expand5(rx_byte[4:0]);
`ifdef ST7789_RX_COLMOD_EN
    if (fmt_q == FMT_RGB666) begin
      last_phase = 2'd2;
      col_r      = expand6(pix0_q[7:2]);
      col_g      = expand6(pix1_q[7:2]);
      col_b      = expand6(rx_byte[7:2]);
    end
`endif
  end

  assign in_range = (x_q < X_LIM) && (y_q < Y_LIM);

  always_comb begin
    state_d      = state_q;
    param_idx_d  = param_idx_q;
    x_start_d    = x_start_q;
    x_end_d      = x_end_q;
    y_start_d    = y_start_q;
    y_end_d      = y_end_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    pix0_d       = pix0_q;
`ifdef ST7789_RX_COLMOD_EN
    pix1_d       = pix1_q;
    fmt_d        = fmt_q;
`endif
    addr_d       = addr_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    write_d      = 1'b0;
    frame_done_d = 1'b0;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    if (rx_valid && !rx_dc) begin
      cmd_byte_d  = rx_byte;
      cmd_valid_d = 1'b1;
      param_idx_d = 3'd0;
      case (rx_byte)
        OP_SWRESET: begin
          state_d   = ST_IDLE;
          x_start_d = 16'd0;
          x_end_d   = X_MAX;
          y_start_d = 16'd0;
          y_end_d   = Y_MAX;
        end
        OP_CASET: state_d = ST_CASET;
        OP_RASET: state_d = ST_RASET;
        OP_RAMWR: begin
          state_d = ST_RAMWR;
          x_d     = x_start_q;
          y_d     = y_start_q;
          phase_d = 2'd0;
        end
`ifdef ST7789_RX_COLMOD_EN
        OP_COLMOD: state_d = ST_COLMOD;
`endif
        default: state_d = ST_SKIP;
      endcase
    end else if (rx_valid) begin
      case (state_q)
        ST_CASET, ST_RASET: begin
          // Big-endian start then end; bytes past the fourth are dropped.
          if (param_idx_q != 3'd4) param_idx_d = param_idx_q + 3'd1;
          if (state_q == ST_CASET) begin
            case (param_idx_q)
              3'd0: x_start_d[15:8] = rx_byte;
              3'd1: x_start_d[7:0]  = rx_byte;
              3'd2: x_end_d[15:8]   = rx_byte;
              3'd3: x_end_d[7:0]    = rx_byte;
              default: ;
            endcase
          end else begin
            case (param_idx_q)
              3'd0: y_start_d[15:8] = rx_byte;
              3'd1: y_start_d[7:0]  = rx_byte;
              3'd2: y_end_d[15:8]   = rx_byte;
              3'd3: y_end_d[7:0]    = rx_byte;
              default: ;
            endcase
          end
        end
        ST_RAMWR: begin
          if (phase_q == last_phase) begin
            phase_d = 2'd0;
            if (in_range) begin
              write_d = 1'b1;
              addr_d  = AW'(32'(y_q) * 32'(X_LIMIT) + 32'(x_q));
              r_d     = col_r;
              g_d     = col_g;
              b_d     = col_b;
            end
            if (x_q == x_end_q) begin
              x_d = x_start_q;
              if (y_q == y_end_q) begin
                y_d          = y_start_q;
                frame_done_d = 1'b1;
              end else begin
                y_d = y_q + 16'd1;
              end
            end else begin
              x_d = x_q + 16'd1;
            end
          end else begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd0) pix0_d = rx_byte;
`ifdef ST7789_RX_COLMOD_EN
            else pix1_d = rx_byte;
`endif
          end
        end
`ifdef ST7789_RX_COLMOD_EN
        ST_COLMOD: begin
          if (param_idx_q == 3'd0) begin
            fmt_d       = (rx_byte[2:0] == 3'b110) ? FMT_RGB666 : FMT_RGB565;
            param_idx_d = 3'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET || !panel_rstn) begin
      state_q      <= ST_IDLE;
      param_idx_q  <= 3'd0;
      x_start_q    <= 16'd0;
      x_end_q      <= X_MAX;
      y_start_q    <= 16'd0;
      y_end_q      <= Y_MAX;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      phase_q      <= 2'd0;
      pix0_q       <= 8'h00;
`ifdef ST7789_RX_COLMOD_EN
      pix1_q       <= 8'h00;
      fmt_q        <= FMT_RGB565;
`endif
      addr_q       <= '0;
      r_q          <= 8'h00;
      g_q          <= 8'h00;
      b_q          <= 8'h00;
      write_q      <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      param_idx_q  <= param_idx_d;
      x_start_q    <= x_start_d;
      x_end_q      <= x_end_d;
      y_start_q    <= y_start_d;
      y_end_q      <= y_end_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      pix0_q       <= pix0_d;
`ifdef ST7789_RX_COLMOD_EN
      pix1_q       <= pix1_d;
      fmt_q        <= fmt_d;
`endif
      addr_q       <= addr_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      write_q      <= write_d;
      frame_done_q <= frame_done_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
    end
  end

  assign WRITE_RAM_ADDRESS = addr_q;
  assign WRITE_RAM_COLOR_R = r_q;
  assign WRITE_RAM_COLOR_G = g_q;
  assign WRITE_RAM_COLOR_B = b_q;
  assign WRITE_RAM         = write_q;
  assign FRAME_DONE        = frame_done_q;
  assign CMD_VALID         = cmd_valid_q;
  assign CMD_BYTE          = cmd_byte_q;

endmodule
